xorshift32_rewind: RTL and testbench
====================================

# xorshift32_rewind

Runs the xorshift32 (13/17/5) sequence backwards. Given a 32-bit generator state S and a step count N, the block returns the state that produced S exactly N forward steps earlier. It is used beside the xorshift32 generator to replay, audit, or re-seed random streams without storing history. Transactions use valid/ready handshakes on both sides, and the block processes one job at a time.

## Interface
- STEPS_W, default 16: width of the step-count input; up to 2^STEPS_W−1 backward steps per job.
- clk  in  1: clock; all state changes on the rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- in_valid  in  1: job request.
- in_ready  out  1: block can accept a job. High only in IDLE.
- in_state  in  32: current generator state S.
- in_steps  in  STEPS_W: number of backward steps N.
- out_valid  out  1: result available.
- out_ready  in  1: consumer accepts the result.
- out_state  out  32: state N steps before S.
- out_err  out  1: in_state was 0. Zero is the all-zero fixed point and is not a valid seed.

## Operation
- Forward step: x ^= x<<13; x ^= x>>17; x ^= x<<5. The three assignments apply in sequence, all 32-bit with truncation.
- A backward step undoes the three stages in reverse order, one stage per cycle. Each stage is a closed-form XOR of the working register r:
  - UNDO5: r ← r ^ r<<5 ^ r<<10 ^ r<<15 ^ r<<20 ^ r<<25 ^ r<<30.
  - UNDO17: r ← r ^ r>>17.
  - UNDO13: r ← r ^ r<<13 ^ r<<26.
- FSM states: IDLE, UNDO5, UNDO17, UNDO13, DONE.
- IDLE: in_ready=1.
  - On in_valid&&in_ready, latch r←in_state, cnt←in_steps, err←(in_state==0).
  - If in_steps==0, go to DONE; otherwise go to UNDO5.
- UNDO5→UNDO17→UNDO13, one cycle each.
- UNDO13: cnt←cnt−1. If cnt==1 (last step), go to DONE; otherwise go to UNDO5.
- DONE: out_valid=1; out_state=r; out_err=err.
  - On out_ready, go to IDLE.
  - out_state and out_err are held stable while out_valid=1 and out_ready=0.
- Zero input: the FSM still runs the full sequence, and out_state=0 with out_err=1. No early exit, so latency does not depend on data.
- in_state and in_steps are sampled only on the accept edge. Later changes are ignored.
- No pipelining: in_ready=0 from the accept edge until the DONE handshake completes.

## Timing
- Reset (async assert, synchronous deassert by the system) forces:
  - state=IDLE, in_ready=1, out_valid=0, out_state=0, out_err=0, r=0, cnt=0.
- Latency: take the accept cycle as cycle 0.
  - out_valid is first high in cycle 3N+1.
  - N=0 gives out_valid in cycle 1.
- Back-to-back throughput: the DONE handshake cycle returns to IDLE, so the next accept happens at the earliest one cycle after the DONE handshake.
- Reset asserted mid-job (any UNDO state or DONE): immediate return to reset values. The partial result is discarded and never presented.
- in_valid high while busy is ignored. The requester must hold in_valid until in_ready.
- out_valid deasserts on the edge following out_valid&&out_ready.

## Test plan
- Single step: in_state=0x00042021, N=1 → out_state=0x00000001, out_err=0, out_valid in cycle 4.
- Multi-step: in_state=0x04080601.
  - N=2 → 0x00000001.
  - N=1 → 0x00042021.
  - out_valid in cycle 7 and cycle 4 respectively.
- Pass-through and zero:
  - in_state=0xDEADBEEF, N=0 → out_state=0xDEADBEEF in cycle 1.
  - in_state=0, N=5 → out_state=0, out_err=1, cycle 16.
- Round trip: drive 1,000 random nonzero seeds through a reference forward model with random N∈[1,300], rewind each → out_state equals the original seed every time.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_state is stable, in_ready stays 0. Toggle in_valid meanwhile → no new job is accepted.
- Reset mid-job: accept N=100, pull reset_n low in cycle 50 → outputs take reset values immediately. After release, a fresh job (0x00042021, N=1) returns 0x00000001.

Source files
------------

// File: rtl/xorshift32_rewind.sv
// xorshift32_rewind
// Walks the xorshift32 (13/17/5) sequence backwards: given a generator state
// S and a step count N, returns the state that produced S N forward steps
// earlier. One backward step takes three cycles, one for each undone stage.
// The block handles one job at a time, with valid/ready on both sides.

module xorshift32_rewind #(
    parameter int STEPS_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_state,
    input  logic [STEPS_W-1:0] in_steps,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_state,
    output logic               out_err
);

    // state     | meaning
    // ----------+-----------------------------------------------------------
    // S_IDLE    | in_ready high, waiting for a job
    // S_UNDO5   | undo  x ^= x<<5  on the working register
    // S_UNDO17  | undo  x ^= x>>17 on the working register
    // S_UNDO13  | undo  x ^= x<<13, count one backward step done
    // S_DONE    | result presented, held until out_ready
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNDO5  = 3'd1,
        S_UNDO17 = 3'd2,
        S_UNDO13 = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        r_q, r_d;
    logic [STEPS_W-1:0] cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_state_q, out_state_d;
    logic               out_err_q, out_err_d;

    // Inverse of x ^= x<<5: the shift contributions keep compounding, so the
    // closed form XORs every multiple of 5 that still fits in 32 bits.
    function automatic logic [31:0] undo5(input logic [31:0] x);
        return x ^ (x << 5) ^ (x << 10) ^ (x << 15) ^ (x << 20) ^ (x << 25) ^ (x << 30);
    endfunction

    // Inverse of x ^= x>>17: a second application already clears bits 34 and up.
    function automatic logic [31:0] undo17(input logic [31:0] x);
        return x ^ (x >> 17);
    endfunction

    // Inverse of x ^= x<<13: terms at 13 and 26 cover all 32 bits.
    function automatic logic [31:0] undo13(input logic [31:0] x);
        return x ^ (x << 13) ^ (x << 26);
    endfunction

    // Next-state and datapath: one undo stage per cycle, outputs precomputed
    // so they can be registered alongside the state.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_err_d   = out_err_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    r_d        = in_state;
                    cnt_d      = in_steps;
                    err_d      = (in_state == 32'd0);
                    in_ready_d = 1'b0;
                    if (in_steps == '0) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        out_state_d = in_state;
                        out_err_d   = (in_state == 32'd0);
                    end else begin
                        state_d = S_UNDO5;
                    end
                end
            end

            S_UNDO5: begin
                r_d     = undo5(r_q);
                state_d = S_UNDO17;
            end

            S_UNDO17: begin
                r_d     = undo17(r_q);
                state_d = S_UNDO13;
            end

            S_UNDO13: begin
                r_d   = undo13(r_q);
                cnt_d = cnt_q - STEPS_W'(1);
                if (cnt_q == STEPS_W'(1)) begin
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                    out_state_d = undo13(r_q);
                    out_err_d   = err_q;
                end else begin
                    state_d = S_UNDO5;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            r_q         <= 32'd0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_state_q <= 32'd0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_xorshift32_rewind.sv
// Bench for xorshift32_rewind: directed jobs with hand-computed results and
// latencies, a forward-model round trip, backpressure and mid-job reset.

module tb_xorshift32_rewind;

    localparam int STEPS_W = 16;

    logic               clk;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_state;
    logic [STEPS_W-1:0] in_steps;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_state;
    logic               out_err;

    int n_tests;
    int n_fail;

    xorshift32_rewind #(.STEPS_W(STEPS_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_steps  (in_steps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference forward generator.
    function automatic logic [31:0] fwd(input logic [31:0] x0, input int n);
        logic [31:0] x;
        x = x0;
        for (int i = 0; i < n; i++) begin
            x = x ^ (x << 13);
            x = x ^ (x >> 17);
            x = x ^ (x << 5);
        end
        return x;
    endfunction

    // Accepts one job, measures the cycle in which out_valid first rises
    // (accept cycle = 0), optionally completes the output handshake.
    task automatic run_job(input string tag, input logic [31:0] s, input int n, input bit do_ack,
                           output logic [31:0] got_state, output logic got_err, output int lat);
        int waitc;
        waitc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_state = s;
        in_steps = STEPS_W'(n);
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check_eq({tag, "_accept_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = 32'hFFFF_FFFF;
        in_steps = '1;
        lat = 1;
        while (!out_valid && lat < 3 * n + 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_done_seen"}, {31'd0, out_valid}, 32'd1);
        got_state = out_state;
        got_err   = out_err;
        if (do_ack) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check_eq({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
            check_eq({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        logic [31:0] gs;
        logic        ge;
        int          lat;
        logic [31:0] seed;
        logic [31:0] held;
        int          n;
        int          cyc;

        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_state  = 32'd0;
        in_steps  = '0;
        out_ready = 1'b0;
        #22;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_state", out_state, 32'd0);
        check_eq("rst_out_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors.
        run_job("single", 32'h0004_2021, 1, 1'b1, gs, ge, lat);
        check_eq("single_state", gs, 32'h0000_0001);
        check_eq("single_err", {31'd0, ge}, 32'd0);
        check_eq("single_lat", lat, 32'd4);

        run_job("two", 32'h0408_0601, 2, 1'b1, gs, ge, lat);
        check_eq("two_state", gs, 32'h0000_0001);
        check_eq("two_lat", lat, 32'd7);

        run_job("one", 32'h0408_0601, 1, 1'b1, gs, ge, lat);
        check_eq("one_state", gs, 32'h0004_2021);
        check_eq("one_lat", lat, 32'd4);

        run_job("pass", 32'hDEAD_BEEF, 0, 1'b1, gs, ge, lat);
        check_eq("pass_state", gs, 32'hDEAD_BEEF);
        check_eq("pass_err", {31'd0, ge}, 32'd0);
        check_eq("pass_lat", lat, 32'd1);

        run_job("zero", 32'd0, 5, 1'b1, gs, ge, lat);
        check_eq("zero_state", gs, 32'd0);
        check_eq("zero_err", {31'd0, ge}, 32'd1);
        check_eq("zero_lat", lat, 32'd16);

        run_job("zero_n0", 32'd0, 0, 1'b1, gs, ge, lat);
        check_eq("zero_n0_err", {31'd0, ge}, 32'd1);

        // Long rewinds against the forward model.
        for (int k = 0; k < 2; k++) begin
            seed = (k == 0) ? 32'h1234_5678 : 32'h8000_0000;
            run_job("long", fwd(seed, 300), 300, 1'b1, gs, ge, lat);
            check_eq("long_state", gs, seed);
            check_eq("long_lat", lat, 32'd901);
        end

        // Round trip on random seeds; N kept short to bound run time.
        for (int k = 0; k < 1000; k++) begin
            seed = $urandom;
            if (seed == 32'd0) seed = 32'h0000_0001;
            n = $urandom_range(1, 24);
            run_job("rt", fwd(seed, n), n, 1'b1, gs, ge, lat);
            check_eq("rt_state", gs, seed);
        end

        // Backpressure: result held, no new job accepted while busy.
        run_job("bp", 32'h0004_2021, 1, 1'b0, gs, ge, lat);
        held = out_state;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_state = 32'h0408_0601;
            in_steps = STEPS_W'(0);
            @(posedge clk);
            #1;
            check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
            check_eq("bp_state", out_state, held);
            check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        check_eq("bp_value", held, 32'h0000_0001);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("bp_release", {31'd0, out_valid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("bp_no_stray", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a long job.
        @(negedge clk);
        in_valid = 1'b1;
        in_state = 32'h0408_0601;
        in_steps = STEPS_W'(100);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("mid_busy", {31'd0, in_ready}, 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_state", out_state, 32'd0);
        check_eq("mid_rst_err", {31'd0, out_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check_eq("mid_no_result", {31'd0, out_valid}, 32'd0);
        run_job("after_rst", 32'h0004_2021, 1, 1'b1, gs, ge, lat);
        check_eq("after_rst_state", gs, 32'h0000_0001);
        check_eq("after_rst_lat", lat, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
